rom_read_arbiter: RTL and testbench
===================================

// Module: rom_read_arbiter
// PURPOSE
// - Shares the single InputDataROM read port among NUM_REQ FIFO-fill lanes using round-robin arbitration.
// - Issues one ROM address per cycle.
// - Tracks the fixed ROM read latency and steers each returned byte to the FIFO of the lane that requested it.
// - Sits between the per-lane fill sequencers and the ROM/systolic-array input FIFOs.
// PARAMETERS
// NUM_REQ  9   number of requesting lanes (one per array input FIFO)
// ADDR_W   20  ROM address width
// DATA_W   8   ROM data width
// RD_LAT   2   ROM read latency, cycles from rom_addr registered to rom_data valid (>=1)
// PORTS
// clk          in   1               clock
// reset        in   1               asynchronous, active-low reset
// enable       in   1               1 = new grants allowed; 0 = stop granting, drain in-flight reads
// req          in   NUM_REQ         per-lane read request, held until granted
// req_addr     in   NUM_REQ*ADDR_W  per-lane address; lane k at [k*ADDR_W +: ADDR_W]
// fifo_afull   in   NUM_REQ         lane FIFO has <= RD_LAT free slots; blocks new grants to that lane
// gnt          out  NUM_REQ         one-hot, 1-cycle pulse; request accepted
// rom_addr     out  ADDR_W          address to ROM port
// rom_en       out  1               ROM read strobe
// rom_data     in   DATA_W          ROM read data
// wr_data      out  DATA_W          data to lane FIFOs; combinational copy of rom_data
// wr_en        out  NUM_REQ         one-hot FIFO write strobe, aligned with valid rom_data
// idle         out  1               no grant issued and no read in flight
// BEHAVIOUR
// - Reset values: gnt=0, rom_en=0, rom_addr=0, wr_en=0, idle=1, rr_ptr=NUM_REQ-1, FSM=IDLE.
// - Reset mid-operation clears the tag pipeline. In-flight reads are dropped, with no wr_en pulse after reset.
// - Eligibility in cycle t: elig[k] = req[k] & ~fifo_afull[k] & ~(k granted in cycle t-1).
//   - A lane is never granted on two consecutive cycles, so a lone requester gets at most 1 grant per 2 cycles.
// - Round-robin: search starts at rr_ptr+1 mod NUM_REQ; the first elig lane wins.
//   - rr_ptr is updated to the winner; it is unchanged when there is no winner.
// - Grant registered at edge t: in cycle t+1, gnt[k]=1, rom_en=1, rom_addr=req_addr[k] (sampled in cycle t).
//   - A requester sees gnt in the same cycle the address is on the ROM.
//   - It advances req_addr/req from the next edge.
// - No grant in a cycle: rom_en=0, gnt=0, rom_addr holds its last value.
// - Tag pipeline: RD_LAT-stage shift register of one-hot lane tags, loaded with gnt each cycle.
//   - wr_en = last stage, so wr_en[k] pulses exactly RD_LAT cycles after gnt[k].
//   - wr_data = rom_data in that cycle.
// - Pipeline always shifts regardless of enable or fifo_afull.
//   - Lanes must size the afull threshold so RD_LAT in-flight writes never overflow.
// - FSM:
//   - IDLE -> RUN when enable=1 and |req.
//   - RUN -> DRAIN when enable=0, or when no req and tags in flight.
//   - RUN -> IDLE when no req and no tags in flight.
//   - DRAIN -> IDLE when the tag pipeline is empty; DRAIN -> RUN when enable=1 and |req.
//   - Grants are issued only in RUN.
// - idle = (FSM==IDLE) & (pipeline empty) & ~gnt.
// - Simultaneous: req and fifo_afull rising on the same lane in the same cycle -> no grant to that lane.
// - Simultaneous: enable falling in the same cycle as an arbitration -> that grant is suppressed.
// - req_addr is not range-checked; the address is forwarded verbatim.
// TESTING
// - T1 single lane: req[3]=1, addr 0x00010, RD_LAT=2.
//   - gnt[3] pulses every other cycle; wr_en[3] follows 2 cycles later with wr_data=ROM[0x00010].
// - T2 all 9 lanes requesting continuously, afull=0.
//   - Grant order 0,1,...,8,0; exactly one gnt per cycle; wr_en tags match that order delayed 2 cycles.
// - T3 backpressure: lanes 0..2 requesting, fifo_afull[1]=1 for 10 cycles.
//   - Grants alternate 0,2 only; lane 1 is granted on the first eligible cycle after afull drops.
// - T4 enable dropped with 2 reads in flight.
//   - No further gnt; both wr_en pulses still occur; idle=1 one cycle after the last wr_en.
// - T5 reset asserted 1 cycle after a grant.
//   - wr_en stays 0, gnt=0, rom_en=0, idle=1; after release, arbitration restarts at lane 0.
// - T6 lane 8 granted, then lanes 8 and 0 requesting.
//   - Next grant is lane 0 (wrap-around plus consecutive-grant mask), then lane 8.

Source files
------------

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one ROM read port among NUM_REQ FIFO-fill lanes.
// A one-hot tag pipeline tracks the ROM latency and steers each returned byte to its lane.
module rom_read_arbiter #(
  parameter int NUM_REQ = 9,
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 8,
  parameter int RD_LAT  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ-1:0]        fifo_afull_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [ADDR_W-1:0]         rom_addr_o,
  output logic                      rom_en_o,
  input  logic [DATA_W-1:0]         rom_data_i,
  output logic [DATA_W-1:0]         wr_data_o,
  output logic [NUM_REQ-1:0]        wr_en_o,
  output logic                      idle_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic               rom_en_q;
  logic               idle_q, idle_d;
  logic [NUM_REQ-1:0] tag_q [RD_LAT];

  logic               grant_ok_s;
  logic               any_req_s;
  logic               inflight_s;
  logic [NUM_REQ-1:0] elig_s;
  logic               win_valid_s;
  logic [IDX_W-1:0]   win_idx_s;
  logic [IDX_W:0]     sum_s;
  logic [IDX_W:0]     cand_s;
  logic               hit_s;

  // A lane granted last cycle still shows req this cycle, so it is masked out.
  always_comb begin
    grant_ok_s = (state_q == ST_RUN) && enable_i;
    any_req_s  = |req_i;
    elig_s     = req_i & ~fifo_afull_i & ~gnt_q & {NUM_REQ{grant_ok_s}};
  end

  always_comb begin
    win_valid_s = 1'b0;
    win_idx_s   = '0;
    sum_s       = '0;
    cand_s      = '0;
    hit_s       = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      sum_s       = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      cand_s      = (sum_s >= (IDX_W+1)'(NUM_REQ)) ? (sum_s - (IDX_W+1)'(NUM_REQ)) : sum_s;
      hit_s       = elig_s[cand_s[IDX_W-1:0]] & ~win_valid_s;
      win_idx_s   = hit_s ? cand_s[IDX_W-1:0] : win_idx_s;
      win_valid_s = win_valid_s | hit_s;
    end
  end

  // Reads that will still be in the tag pipeline after the next shift.
  always_comb begin
    inflight_s = |gnt_q;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      inflight_s = inflight_s | (|tag_q[i]);
    end
  end

  always_comb begin
    gnt_d = '0;
    if (win_valid_s) begin
      gnt_d[win_idx_s] = 1'b1;
    end else begin
      gnt_d = '0;
    end
    rr_ptr_d   = win_valid_s ? win_idx_s : rr_ptr_q;
    rom_addr_d = win_valid_s ? req_addr_i[win_idx_s*ADDR_W +: ADDR_W] : rom_addr_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        state_d = (enable_i && any_req_s) ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        if (!enable_i) begin
          state_d = ST_DRAIN;
        end else if (!any_req_s) begin
          state_d = inflight_s ? ST_DRAIN : ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!inflight_s) begin
          state_d = ST_IDLE;
        end else if (enable_i && any_req_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    idle_d = (state_d == ST_IDLE) && !inflight_s && !(|gnt_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
      gnt_q      <= '0;
      rom_addr_q <= '0;
      rom_en_q   <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      rom_addr_q <= rom_addr_d;
      rom_en_q   <= win_valid_s;
      idle_q     <= idle_d;
    end
  end

  // Tag pipeline shifts unconditionally; its last stage is the FIFO write strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= gnt_q;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign gnt_o      = gnt_q;
  assign rom_addr_o = rom_addr_q;
  assign rom_en_o   = rom_en_q;
  assign wr_en_o    = tag_q[RD_LAT-1];
  assign wr_data_o  = rom_data_i;
  assign idle_o     = idle_q;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench for rom_read_arbiter: directed scenarios plus random traffic against a
// transaction-level model (round-robin pick, FSM rules, scoreboard of expected writes).
module tb_rom_read_arbiter;

  localparam int N   = 9;
  localparam int AW  = 20;
  localparam int DW  = 8;
  localparam int LAT = 2;
  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_DRAIN = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    afull;
  logic [N-1:0]    gnt;
  logic [AW-1:0]   rom_addr;
  logic            rom_en;
  logic [DW-1:0]   rom_data;
  logic [DW-1:0]   wr_data;
  logic [N-1:0]    wr_en;
  logic            idle;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rom_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .enable_i(enable), .req_i(req), .req_addr_i(req_addr),
    .fifo_afull_i(afull), .gnt_o(gnt), .rom_addr_o(rom_addr), .rom_en_o(rom_en),
    .rom_data_i(rom_data), .wr_data_o(wr_data), .wr_en_o(wr_en), .idle_o(idle)
  );

  function automatic logic [7:0] rom_f(input logic [19:0] a);
    return a[7:0] ^ a[15:8] ^ {a[19:16], a[19:16]} ^ 8'hA5;
  endfunction

  // ROM with a fixed LAT-cycle read latency
  logic [AW-1:0] a_pipe [LAT];
  always @(posedge clk) begin
    a_pipe[0] <= rom_addr;
    for (int i = 1; i < LAT; i++) a_pipe[i] <= a_pipe[i-1];
  end
  assign rom_data = rom_f(a_pipe[LAT-1]);

  typedef struct { int lane; int due; logic [7:0] data; } wr_t;
  wr_t exp_q[$];

  int            cyc = 0;
  int            m_state, m_ptr, m_gnt;
  logic [AW-1:0] m_addr;
  logic          m_en;
  logic [N-1:0]  e_gnt, e_wr_en;
  logic [DW-1:0] e_wr_data;
  logic          e_idle;

  task automatic set_addr(input int k, input logic [AW-1:0] a);
    req_addr[k*AW +: AW] = a;
  endtask

  task automatic model_init();
    exp_q.delete();
    m_state = S_IDLE; m_ptr = N - 1; m_gnt = -1; m_addr = '0; m_en = 1'b0;
    e_gnt = '0; e_wr_en = '0; e_wr_data = '0; e_idle = 1'b1;
  endtask

  // Model decides from this cycle's inputs, clock advances, expectations for the new cycle are set.
  task automatic tick();
    int  win = -1;
    bit  infl = 0;
    int  ns;
    if (m_state == S_RUN && enable) begin
      for (int i = 1; i <= N; i++) begin
        int k = (m_ptr + i) % N;
        if (win < 0 && req[k] && !afull[k] && k != m_gnt) win = k;
      end
    end
    foreach (exp_q[j]) if (exp_q[j].due > cyc) infl = 1;
    ns = m_state;
    case (m_state)
      S_IDLE:  if (enable && |req) ns = S_RUN;
      S_RUN:   if (!enable) ns = S_DRAIN; else if (!(|req)) ns = infl ? S_DRAIN : S_IDLE;
      S_DRAIN: if (!infl) ns = S_IDLE; else if (enable && |req) ns = S_RUN;
      default: ns = S_IDLE;
    endcase
    if (win >= 0) begin
      logic [AW-1:0] a = req_addr[win*AW +: AW];
      exp_q.push_back('{lane: win, due: cyc + 1 + LAT, data: rom_f(a)});
      m_ptr = win; m_addr = a;
    end
    m_en = (win >= 0); m_gnt = win; m_state = ns;
    @(posedge clk);
    cyc++;
    e_gnt = (m_gnt >= 0) ? (9'd1 << m_gnt) : 9'd0;
    e_wr_en = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e_wr_en = 9'd1 << exp_q[0].lane;
      e_wr_data = exp_q[0].data;
      void'(exp_q.pop_front());
    end
    e_idle = (m_state == S_IDLE) && (m_gnt < 0) && (exp_q.size() == 0) && (e_wr_en == 9'd0);
    @(negedge clk);
  endtask

  task automatic hold_reset();
    @(negedge clk);
    reset = 1'b0; enable = 1'b0; req = '0; afull = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_init();
  endtask

  task automatic restart();
    hold_reset();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    hold_reset();
    n_cmp += 5;
    if (gnt !== 9'd0)      begin n_err++; $display("FAIL reset_gnt: got %h want 000", gnt); end
    if (rom_en !== 1'b0)   begin n_err++; $display("FAIL reset_rom_en: got %b want 0", rom_en); end
    if (rom_addr !== 20'd0) begin n_err++; $display("FAIL reset_rom_addr: got %h want 00000", rom_addr); end
    if (wr_en !== 9'd0)    begin n_err++; $display("FAIL reset_wr_en: got %h want 000", wr_en); end
    if (idle !== 1'b1)     begin n_err++; $display("FAIL reset_idle: got %b want 1", idle); end
    reset = 1'b1;
  endtask

  task automatic test_single_lane();
    int n_g = 0, n_w = 0;
    logic [N-1:0] prev = '0;
    restart();
    enable = 1'b1; req = 9'd1 << 3; set_addr(3, 20'h00010);
    for (int t = 0; t < 16; t++) begin
      tick();
      n_cmp += 3;
      if (gnt !== e_gnt) begin n_err++; $display("FAIL t1_gnt: cyc %0d got %h want %h", cyc, gnt, e_gnt); end
      if (wr_en !== e_wr_en) begin n_err++; $display("FAIL t1_wr_en: cyc %0d got %h want %h", cyc, wr_en, e_wr_en); end
      if ((gnt & prev) !== 9'd0) begin n_err++; $display("FAIL t1_consecutive: cyc %0d got %h after %h", cyc, gnt, prev); end
      if (gnt[3]) begin
        n_g++; n_cmp++;
        if (rom_addr !== 20'h00010) begin n_err++; $display("FAIL t1_rom_addr: got %h want 00010", rom_addr); end
      end
      if (wr_en[3]) begin
        n_w++; n_cmp++;
        if (wr_data !== rom_f(20'h00010)) begin n_err++; $display("FAIL t1_wr_data: got %h want %h", wr_data, rom_f(20'h00010)); end
      end
      prev = gnt;
    end
    n_cmp += 2;
    if (n_g != 8) begin n_err++; $display("FAIL t1_gnt_count: got %0d want 8", n_g); end
    if (n_w != 7) begin n_err++; $display("FAIL t1_wr_count: got %0d want 7", n_w); end
  endtask

  task automatic test_all_lanes();
    int seq[$];
    logic [N-1:0] hist[$];
    bit started = 0;
    restart();
    enable = 1'b1; req = '1;
    for (int k = 0; k < N; k++) set_addr(k, AW'(32'h100 * k + k));
    for (int t = 0; t < 30; t++) begin
      tick();
      hist.push_back(gnt);
      if (gnt !== 9'd0) started = 1;
      for (int k = 0; k < N; k++) if (gnt[k]) seq.push_back(k);
      if (started) begin
        n_cmp++;
        if ($countones(gnt) != 1) begin n_err++; $display("FAIL t2_onehot: cyc %0d got %h want one bit", cyc, gnt); end
      end
      if (t >= LAT) begin
        n_cmp++;
        if (wr_en !== hist[t-LAT]) begin n_err++; $display("FAIL t2_wr_tag: cyc %0d got %h want %h", cyc, wr_en, hist[t-LAT]); end
      end
      if (wr_en !== 9'd0) begin
        n_cmp++;
        if (wr_data !== e_wr_data) begin n_err++; $display("FAIL t2_wr_data: got %h want %h", wr_data, e_wr_data); end
      end
    end
    n_cmp++;
    if (seq.size() < 10) begin n_err++; $display("FAIL t2_grant_count: got %0d want >=10", seq.size()); end
    else begin
      for (int i = 0; i < 10; i++) begin
        n_cmp++;
        if (seq[i] != i % N) begin n_err++; $display("FAIL t2_order: grant %0d got lane %0d want %0d", i, seq[i], i % N); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit got1 = 0;
    restart();
    enable = 1'b1; req = 9'b000000111; afull = 9'b000000010;
    for (int k = 0; k < 3; k++) set_addr(k, AW'(32'h2000 + k));
    for (int t = 0; t < 10; t++) begin
      tick();
      n_cmp += 2;
      if (gnt[1] !== 1'b0) begin n_err++; $display("FAIL t3_blocked: cyc %0d got %h want bit1 clear", cyc, gnt); end
      if (gnt !== e_gnt) begin n_err++; $display("FAIL t3_gnt: cyc %0d got %h want %h", cyc, gnt, e_gnt); end
    end
    afull = '0;
    for (int t = 0; t < 8; t++) begin
      tick();
      n_cmp += 2;
      if (gnt !== e_gnt) begin n_err++; $display("FAIL t3_gnt_after: cyc %0d got %h want %h", cyc, gnt, e_gnt); end
      if (wr_en !== e_wr_en) begin n_err++; $display("FAIL t3_wr_en: cyc %0d got %h want %h", cyc, wr_en, e_wr_en); end
      if (gnt[1]) got1 = 1;
    end
    n_cmp++;
    if (!got1) begin n_err++; $display("FAIL t3_lane1_resume: got no grant want grant to lane 1"); end
  endtask

  task automatic test_enable_drop();
    bit found = 0;
    int n_w = 0, last_w = -1, first_idle = -1;
    restart();
    enable = 1'b1; req = 9'b000000011; set_addr(0, 20'h0A0A0); set_addr(1, 20'h1B1B1);
    for (int t = 0; t < 10 && !found; t++) begin
      tick();
      if (gnt[1]) found = 1;
    end
    n_cmp++;
    if (!found) begin n_err++; $display("FAIL t4_timeout: got no grant to lane 1 want one within 10 cycles"); end
    enable = 1'b0;
    for (int t = 0; t < 8; t++) begin
      tick();
      n_cmp += 3;
      if (gnt !== 9'd0) begin n_err++; $display("FAIL t4_no_gnt: cyc %0d got %h want 000", cyc, gnt); end
      if (wr_en !== e_wr_en) begin n_err++; $display("FAIL t4_wr_en: cyc %0d got %h want %h", cyc, wr_en, e_wr_en); end
      if (idle !== e_idle) begin n_err++; $display("FAIL t4_idle: cyc %0d got %b want %b", cyc, idle, e_idle); end
      if (wr_en !== 9'd0) begin n_w++; last_w = t; end
      if (idle === 1'b1 && first_idle < 0) first_idle = t;
    end
    n_cmp += 2;
    if (n_w != 2) begin n_err++; $display("FAIL t4_wr_count: got %0d want 2", n_w); end
    if (first_idle != last_w + 1) begin n_err++; $display("FAIL t4_idle_timing: got idle at %0d want %0d", first_idle, last_w + 1); end
    req = '0;
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    restart();
    enable = 1'b1; req = 9'd1 << 5; set_addr(5, 20'h55555);
    for (int t = 0; t < 10 && !found; t++) begin
      tick();
      if (gnt[5]) found = 1;
    end
    tick();
    reset = 1'b0;
    #1;
    n_cmp += 5;
    if (!found) begin n_err++; $display("FAIL t5_timeout: got no grant want one within 10 cycles"); end
    if (gnt !== 9'd0)    begin n_err++; $display("FAIL t5_gnt: got %h want 000", gnt); end
    if (rom_en !== 1'b0) begin n_err++; $display("FAIL t5_rom_en: got %b want 0", rom_en); end
    if (idle !== 1'b1)   begin n_err++; $display("FAIL t5_idle: got %b want 1", idle); end
    if (wr_en !== 9'd0)  begin n_err++; $display("FAIL t5_wr_en: got %h want 000", wr_en); end
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      n_cmp++;
      if (wr_en !== 9'd0) begin n_err++; $display("FAIL t5_wr_en_hold: got %h want 000", wr_en); end
    end
    model_init();
    req = '1; reset = 1'b1;
    found = 0;
    for (int t = 0; t < 10 && !found; t++) begin
      tick();
      if (gnt !== 9'd0) begin
        found = 1; n_cmp++;
        if (gnt !== 9'd1) begin n_err++; $display("FAIL t5_restart_lane0: got %h want 001", gnt); end
      end
    end
    n_cmp++;
    if (!found) begin n_err++; $display("FAIL t5_restart_timeout: got no grant want one within 10 cycles"); end
    req = '0;
  endtask

  task automatic test_wrap();
    bit found = 0;
    restart();
    enable = 1'b1; req = 9'd1 << 8; set_addr(8, 20'h88888); set_addr(0, 20'h00123);
    for (int t = 0; t < 12 && !found; t++) begin
      tick();
      if (gnt[8]) found = 1;
    end
    n_cmp++;
    if (!found) begin n_err++; $display("FAIL t6_timeout: got no grant to lane 8 want one within 12 cycles"); end
    req = 9'b100000001;
    tick();
    n_cmp += 2;
    if (gnt !== 9'b000000001) begin n_err++; $display("FAIL t6_first: got %h want 001", gnt); end
    if (rom_addr !== 20'h00123) begin n_err++; $display("FAIL t6_addr: got %h want 00123", rom_addr); end
    tick();
    n_cmp++;
    if (gnt !== 9'b100000000) begin n_err++; $display("FAIL t6_second: got %h want 100", gnt); end
    req = '0;
  endtask

  task automatic test_random();
    restart();
    for (int t = 0; t < 400; t++) begin
      enable = ($urandom_range(0, 15) != 0);
      req    = N'($urandom);
      afull  = N'($urandom & $urandom & $urandom);
      for (int k = 0; k < N; k++) set_addr(k, AW'($urandom));
      tick();
      n_cmp += 5;
      if (gnt !== e_gnt)       begin n_err++; $display("FAIL rnd_gnt: cyc %0d got %h want %h", cyc, gnt, e_gnt); end
      if (rom_en !== m_en)     begin n_err++; $display("FAIL rnd_rom_en: cyc %0d got %b want %b", cyc, rom_en, m_en); end
      if (rom_addr !== m_addr) begin n_err++; $display("FAIL rnd_rom_addr: cyc %0d got %h want %h", cyc, rom_addr, m_addr); end
      if (wr_en !== e_wr_en)   begin n_err++; $display("FAIL rnd_wr_en: cyc %0d got %h want %h", cyc, wr_en, e_wr_en); end
      if (idle !== e_idle)     begin n_err++; $display("FAIL rnd_idle: cyc %0d got %b want %b", cyc, idle, e_idle); end
      if (e_wr_en !== 9'd0) begin
        n_cmp++;
        if (wr_data !== e_wr_data) begin n_err++; $display("FAIL rnd_wr_data: cyc %0d got %h want %h", cyc, wr_data, e_wr_data); end
      end
    end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; req = '0; afull = '0; req_addr = '0;
    model_init();
    test_reset();
    test_single_lane();
    test_all_lanes();
    test_backpressure();
    test_enable_drop();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
